// File: rtl/muldiv_hilo.sv
// Iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a one-cycle multiplier.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic             neg_q, neg_rem_q, is_div_q, dbz_q;

  logic             a_neg, b_neg, b_zero, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Even op codes are the signed variants; magnitudes feed an unsigned core.
  assign a_neg  = ~op[0] & a[WIDTH-1];
  assign b_neg  = ~op[0] & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);
  assign last   = (cnt == CW'(WIDTH - 1));

  // acc_hi:acc_lo is the partial product (mul) or remainder:quotient (div).
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem_q ? -acc_hi : acc_hi;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opb       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dbz_q     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                neg_q    <= a_neg ^ b_neg;
                is_div_q <= 1'b0;
                cnt      <= '0;
`ifdef MULDIV_FAST_MUL_EN
                {acc_hi, acc_lo} <= fast_prod;
                state            <= S_FIX;
`else
                acc_hi <= '0;
                acc_lo <= b_mag;
                opb    <= a_mag;
                state  <= S_MUL;
`endif
              end
              OP_DIV, OP_DIVU: begin
                if (b_zero) begin
                  hi    <= a;
                  lo    <= '1;
                  dbz_q <= 1'b1;
                  state <= S_DONE;
                end else begin
                  acc_hi    <= '0;
                  acc_lo    <= a_mag;
                  opb       <= b_mag;
                  neg_q     <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  is_div_q  <= 1'b1;
                  cnt       <= '0;
                  state     <= S_DIV;
                end
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) state <= S_FIX;
        end
        S_DIV: begin
          if (!div_diff[WIDTH]) begin
            acc_hi <= div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          dbz_q <= 1'b0;
          state <= S_DONE;
        end
        S_DONE: begin
          dbz_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign done        = (state == S_DONE);
  assign div_by_zero = done & dbz_q;

endmodule
